// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bridge_pkg
//  Purpose  : Shared definitions for the M-stage memory bridge.
//             - Address windows (inclusive base/limit) for DM, TC0, TC1, INT
//             - Target select encoding (3 bits)
//             - Bridge FSM state encoding
//             - Inclusive range-check helper used by the decoder
//  Revision : 1.0  initial release
// ============================================================================
package bridge_pkg;

    localparam logic [31:0] C_DM_BASE   = 32'h0000_0000;
    localparam logic [31:0] C_DM_LIMIT  = 32'h0000_2FFF;
    localparam logic [31:0] C_TC0_BASE  = 32'h0000_7F00;
    localparam logic [31:0] C_TC0_LIMIT = 32'h0000_7F0B;
    localparam logic [31:0] C_TC1_BASE  = 32'h0000_7F10;
    localparam logic [31:0] C_TC1_LIMIT = 32'h0000_7F1B;
    localparam logic [31:0] C_INT_BASE  = 32'h0000_7F20;
    localparam logic [31:0] C_INT_LIMIT = 32'h0000_7F23;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_DM   = 3'd1,
        SEL_TC0  = 3'd2,
        SEL_TC1  = 3'd3,
        SEL_INT  = 3'd4
    } sel_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bridge_decode.sv
`default_nettype none
// ============================================================================
//  Module   : bridge_decode
//  Purpose  : Combinational address decoder for the memory bridge.
//  Ports    : cpu_addr   in  32  byte address
//             cpu_we     in  1   1=store
//             cpu_byteen in  4   store byte enables
//             sel        out 3   selected target (sel_e)
//             err        out 1   partial-word store to a timer (illegal)
//  Revision : 1.0  initial release
// ============================================================================
module bridge_decode
    import bridge_pkg::*;
(
    input  logic [31:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_byteen,
    output sel_e        sel,
    output logic        err
);

    always_comb begin
        sel = SEL_NONE;
        if (in_range(cpu_addr, C_DM_BASE, C_DM_LIMIT)) begin
            sel = SEL_DM;
        end else if (in_range(cpu_addr, C_TC0_BASE, C_TC0_LIMIT)) begin
            sel = SEL_TC0;
        end else if (in_range(cpu_addr, C_TC1_BASE, C_TC1_LIMIT)) begin
            sel = SEL_TC1;
        end else if (in_range(cpu_addr, C_INT_BASE, C_INT_LIMIT)) begin
            sel = SEL_INT;
        end
    end

    // Timer registers are word-only; any partial store is rejected.
    assign err = cpu_we && ((sel == SEL_TC0) || (sel == SEL_TC1)) && (cpu_byteen != 4'b1111);

endmodule
`default_nettype wire

// File: rtl/mem_bridge_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bridge_ctrl
//  Purpose  : M-stage system-bus controller. Decodes CPU load/store addresses
//             to DM / TC0 / TC1 / INT, sequences per-target wait states,
//             stalls the pipeline until completion and flags bus errors.
//  Ports    : clk, reset (sync, active-high)
//             cpu_req/we/addr/byteen/wdata/flush  -> CPU request side
//             cpu_rdata/ack/stall, bus_err        <- CPU response side
//             dm_addr/byteen/wdata, dm_rdata      DM interface
//             tc0_we/tc1_we/tc_addr/tc_wdata, tc0_rdata/tc1_rdata  timers
//             int_we                              interrupt generator
//             perf_stall_cnt/perf_err_cnt         only with BRIDGE_PERF_EN
//  Config   : BRIDGE_PERF_EN adds the two 32-bit performance counters.
//             CNT_W must satisfy 2**CNT_W > max(DM_WAIT, TC_WAIT).
//  Revision : 1.0  initial release
// ============================================================================
module mem_bridge_ctrl
    import bridge_pkg::*;
#(
    parameter int DM_WAIT = 0,
    parameter int TC_WAIT = 1,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_byteen,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_flush,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    output logic        bus_err,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_byteen,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        tc0_we,
    output logic        tc1_we,
    output logic [29:0] tc_addr,
    output logic [31:0] tc_wdata,
    input  logic [31:0] tc0_rdata,
    input  logic [31:0] tc1_rdata,
    output logic        int_we
`ifdef BRIDGE_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_err_cnt
`endif
);

    localparam logic [CNT_W-1:0] C_DM_WAIT = CNT_W'(DM_WAIT);
    localparam logic [CNT_W-1:0] C_TC_WAIT = CNT_W'(TC_WAIT);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    sel_e             sel;
    logic             err;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wait_sel;
    logic             ack, berr, fire;
    logic [31:0]      rdata_mux;

    bridge_decode u_decode (
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .cpu_byteen (cpu_byteen),
        .sel        (sel),
        .err        (err)
    );

    assign wait_sel = (sel == SEL_DM) ? C_DM_WAIT : C_TC_WAIT;

    // Next-state logic. While reset is high nothing is accepted, so every
    // response and strobe stays low in the reset cycle itself.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack     = 1'b0;
        berr    = 1'b0;
        fire    = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req && !cpu_flush) begin
                        if ((sel == SEL_NONE) || err) begin
                            ack  = 1'b1;
                            berr = 1'b1;
                        end else if (wait_sel == '0) begin
                            ack  = 1'b1;
                            fire = 1'b1;
                        end else begin
                            cnt_d   = wait_sel - C_CNT_ONE;
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // A flush, or a dropped request, abandons the access
                    // without ever strobing the target.
                    if (cpu_flush || !cpu_req) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - C_CNT_ONE;
                    end else begin
                        ack     = 1'b1;
                        fire    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        rdata_mux = '0;
        case (sel)
            SEL_DM:  rdata_mux = dm_rdata;
            SEL_TC0: rdata_mux = tc0_rdata;
            SEL_TC1: rdata_mux = tc1_rdata;
            default: rdata_mux = '0;
        endcase
    end

    assign cpu_ack   = ack;
    assign bus_err   = berr;
    assign cpu_stall = cpu_req && !ack && !cpu_flush && !reset;
    assign cpu_rdata = (ack && !berr) ? rdata_mux : 32'h0;

    assign dm_addr   = cpu_addr;
    assign dm_wdata  = cpu_wdata;
    assign tc_addr   = cpu_addr[31:2];
    assign tc_wdata  = cpu_wdata;

    // fire is only ever high in an ack cycle of a legal access.
    assign dm_byteen = (fire && cpu_we && (sel == SEL_DM)) ? cpu_byteen : 4'b0000;
    assign tc0_we    = fire && cpu_we && (sel == SEL_TC0);
    assign tc1_we    = fire && cpu_we && (sel == SEL_TC1);
    assign int_we    = fire && cpu_we && (sel == SEL_INT);

`ifdef BRIDGE_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_err_q,   perf_err_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'b0, cpu_stall};
        perf_err_d   = perf_err_q   + {31'b0, bus_err};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_err_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_err_q   <= perf_err_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_err_cnt   = perf_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bridge_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bridge_ctrl
//  Purpose  : Self-checking bench for mem_bridge_ctrl. Instance dut uses the
//             default waits (DM 0, TC 1); dut3 uses TC_WAIT=3. Both share the
//             same request inputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_bridge_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_flush = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]  cpu_byteen = '0;
    logic [31:0] dm_rdata, tc0_rdata, tc1_rdata;

    always #5 clk = ~clk;

    // Target read data models: DM echoes its address under a tag.
    assign dm_rdata  = 32'hDA7A_0000 ^ cpu_addr;
    assign tc0_rdata = 32'h0000_1234;
    assign tc1_rdata = 32'h5678_9ABC;

    logic [31:0] cpu_rdata, dm_addr, dm_wdata, tc_wdata;
    logic        cpu_ack, cpu_stall, bus_err, tc0_we, tc1_we, int_we;
    logic [3:0]  dm_byteen;
    logic [29:0] tc_addr;
    logic [31:0] d3_cpu_rdata, d3_dm_addr, d3_dm_wdata, d3_tc_wdata;
    logic        d3_cpu_ack, d3_cpu_stall, d3_bus_err, d3_tc0_we, d3_tc1_we, d3_int_we;
    logic [3:0]  d3_dm_byteen;
    logic [29:0] d3_tc_addr;
`ifdef BRIDGE_PERF_EN
    logic [31:0] perf_stall_cnt, perf_err_cnt, d3_perf_stall_cnt, d3_perf_err_cnt;
`endif

    mem_bridge_ctrl dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_byteen(cpu_byteen), .cpu_wdata(cpu_wdata),
        .cpu_flush(cpu_flush), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .cpu_stall(cpu_stall), .bus_err(bus_err), .dm_addr(dm_addr),
        .dm_byteen(dm_byteen), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .tc0_we(tc0_we), .tc1_we(tc1_we), .tc_addr(tc_addr), .tc_wdata(tc_wdata),
        .tc0_rdata(tc0_rdata), .tc1_rdata(tc1_rdata), .int_we(int_we)
`ifdef BRIDGE_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_err_cnt(perf_err_cnt)
`endif
    );

    mem_bridge_ctrl #(.DM_WAIT(0), .TC_WAIT(3), .CNT_W(4)) dut3 (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_byteen(cpu_byteen), .cpu_wdata(cpu_wdata),
        .cpu_flush(cpu_flush), .cpu_rdata(d3_cpu_rdata), .cpu_ack(d3_cpu_ack),
        .cpu_stall(d3_cpu_stall), .bus_err(d3_bus_err), .dm_addr(d3_dm_addr),
        .dm_byteen(d3_dm_byteen), .dm_wdata(d3_dm_wdata), .dm_rdata(dm_rdata),
        .tc0_we(d3_tc0_we), .tc1_we(d3_tc1_we), .tc_addr(d3_tc_addr), .tc_wdata(d3_tc_wdata),
        .tc0_rdata(tc0_rdata), .tc1_rdata(tc1_rdata), .int_we(d3_int_we)
`ifdef BRIDGE_PERF_EN
        , .perf_stall_cnt(d3_perf_stall_cnt), .perf_err_cnt(d3_perf_err_cnt)
`endif
    );

    // Observation bundle: {ack, stall, err, rdata, dm_byteen, tc0_we, tc1_we, int_we}
    logic [41:0] obs, obs3;
    assign obs  = {cpu_ack, cpu_stall, bus_err, cpu_rdata, dm_byteen, tc0_we, tc1_we, int_we};
    assign obs3 = {d3_cpu_ack, d3_cpu_stall, d3_bus_err, d3_cpu_rdata, d3_dm_byteen,
                   d3_tc0_we, d3_tc1_we, d3_int_we};

    function automatic logic [41:0] mk(input logic ack, input logic stall, input logic err,
                                       input logic [31:0] rd, input logic [3:0] be,
                                       input logic t0, input logic t1, input logic iw);
        return {ack, stall, err, rd, be, t0, t1, iw};
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard: expected ack-cycle responses queued at issue time.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  dmbe;
        logic        t0, t1, iw;
    } exp_t;

    exp_t sbq[$];
    exp_t sb_e;
    bit   sb_en = 1'b0;
    int   n_strobe = 0;
    logic any_strobe;

    assign any_strobe = (dm_byteen != 4'b0) || tc0_we || tc1_we || int_we;

    function automatic exp_t mk_e(input logic [31:0] rd, input logic err, input logic [3:0] be,
                                  input logic t0, input logic t1, input logic iw);
        exp_t e;
        e.rdata = rd; e.err = err; e.dmbe = be; e.t0 = t0; e.t1 = t1; e.iw = iw;
        return e;
    endfunction

    always @(negedge clk) begin
        if (sb_en) begin
            if (any_strobe) n_strobe++;
            if (cpu_ack) begin
                if (sbq.size() == 0) begin
                    check("sb_unexpected_ack", {63'b0, cpu_ack}, 64'd0);
                end else begin
                    sb_e = sbq.pop_front();
                    check("sb_ack_resp",
                          {cpu_rdata, bus_err, dm_byteen, tc0_we, tc1_we, int_we},
                          {sb_e.rdata, sb_e.err, sb_e.dmbe, sb_e.t0, sb_e.t1, sb_e.iw});
                end
            end else if (any_strobe) begin
                check("strobe_without_ack", {dm_byteen, tc0_we, tc1_we, int_we}, 64'd0);
            end
        end
    end

    // The bench must keep a stalled request asserted unless it flushes it.
    assert property (@(posedge clk) disable iff (reset || !sb_en)
                     cpu_stall |=> (cpu_req || cpu_flush))
        else $error("protocol: cpu_req dropped during stall");

    // Issue one access on dut (inputs change at posedge+1) and wait for its ack.
    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input int exp_lat, input exp_t e,
                          input string name);
        int  lat = 0;
        bit  done = 1'b0;
        sbq.push_back(e);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_byteen = be;
        cpu_wdata = wd; cpu_flush = 1'b0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (cpu_ack) done = 1'b1;
            else check({name, "_stall"}, {63'b0, cpu_stall}, 64'd1);
            @(posedge clk); #1;
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        cpu_req = 1'b0;
    endtask

    task automatic do_reset();
        cpu_req = 1'b0; cpu_flush = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Single-cycle vector table (all rows complete or do nothing in IDLE)
    // ------------------------------------------------------------------
    typedef struct {
        string       name;
        logic        req, we, flush;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        logic [41:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int base_strobe;
        logic sticky;
        int lat;

        tbl[0] = '{"dm_st_0x10",    1, 1, 0, 32'h0000_0010, 32'h0000_BEEF, 4'b0011,
                   mk(1, 0, 0, 32'hDA7A_0010, 4'b0011, 0, 0, 0)};
        tbl[1] = '{"dm_ld_top",     1, 0, 0, 32'h0000_2FFC, 32'h0, 4'b1111,
                   mk(1, 0, 0, 32'hDA7A_2FFC, 4'b0000, 0, 0, 0)};
        tbl[2] = '{"unmapped_3000", 1, 0, 0, 32'h0000_3000, 32'h0, 4'b1111,
                   mk(1, 0, 1, 32'h0, 4'b0000, 0, 0, 0)};
        tbl[3] = '{"tc1_part_st",   1, 1, 0, 32'h0000_7F10, 32'h11, 4'b0001,
                   mk(1, 0, 1, 32'h0, 4'b0000, 0, 0, 0)};
        tbl[4] = '{"tc_gap_7f0c",   1, 0, 0, 32'h0000_7F0C, 32'h0, 4'b1111,
                   mk(1, 0, 1, 32'h0, 4'b0000, 0, 0, 0)};
        tbl[5] = '{"past_int_7f24", 1, 1, 0, 32'h0000_7F24, 32'h5, 4'b1111,
                   mk(1, 0, 1, 32'h0, 4'b0000, 0, 0, 0)};
        tbl[6] = '{"unmapped_high", 1, 0, 0, 32'hFFFF_FFFC, 32'h0, 4'b1111,
                   mk(1, 0, 1, 32'h0, 4'b0000, 0, 0, 0)};
        tbl[7] = '{"no_req",        0, 1, 0, 32'h0000_0010, 32'h1, 4'b1111,
                   mk(0, 0, 0, 32'h0, 4'b0000, 0, 0, 0)};
        tbl[8] = '{"flush_dm_st",   1, 1, 1, 32'h0000_0010, 32'h2, 4'b1111,
                   mk(0, 0, 0, 32'h0, 4'b0000, 0, 0, 0)};
        tbl[9] = '{"dm_st_full",    1, 1, 0, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111,
                   mk(1, 0, 0, 32'hDA7A_0000, 4'b1111, 0, 0, 0)};

        // Reset: a request presented during reset must not be acted on.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_byteen = 4'hF;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_outputs", 64'(obs), 64'd0);
`ifdef BRIDGE_PERF_EN
        check("reset_perf", {perf_stall_cnt, perf_err_cnt}, 64'd0);
`endif
        @(posedge clk); #1;
        cpu_req = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cpu_req = tbl[i].req; cpu_we = tbl[i].we; cpu_flush = tbl[i].flush;
            cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wdata; cpu_byteen = tbl[i].be;
            @(negedge clk);
            check(tbl[i].name, 64'(obs), 64'(tbl[i].exp));
            if (i == 0) begin
                check("passthru_dm", {dm_addr, dm_wdata}, {32'h10, 32'h0000_BEEF});
                check("passthru_tc", {2'b0, tc_addr, tc_wdata}, {2'b0, 30'h4, 32'h0000_BEEF});
                check("d3_passthru", {60'b0, d3_dm_addr == cpu_addr, d3_tc_addr == cpu_addr[31:2],
                                      d3_dm_wdata == cpu_wdata, d3_tc_wdata == cpu_wdata}, 64'hF);
            end
            @(posedge clk); #1;
        end
        cpu_req = 1'b0; cpu_flush = 1'b0;
        @(posedge clk); #1;

        // Wait-state accesses through the scoreboard.
        sb_en = 1'b1;
        access(1'b0, 32'h7F04, 4'hF, 32'h0, 2, mk_e(32'h1234, 0, 4'h0, 0, 0, 0), "tc0_ld");
        access(1'b1, 32'h7F20, 4'hF, 32'h1, 2, mk_e(32'h0, 0, 4'h0, 0, 0, 1), "int_st");
        access(1'b0, 32'h7F18, 4'hF, 32'h0, 2, mk_e(32'h5678_9ABC, 0, 4'h0, 0, 0, 0), "tc1_ld");

        // Back-to-back DM load, TC0 store, DM store: acks on cycles 1, 3, 4.
        do_reset();
        base_strobe = n_strobe;
        access(1'b0, 32'h20,   4'hF,    32'h0,      1, mk_e(32'hDA7A_0020, 0, 4'h0, 0, 0, 0), "b2b_dm_ld");
        access(1'b1, 32'h7F00, 4'hF,    32'hA5A5,   2, mk_e(32'h1234, 0, 4'h0, 1, 0, 0),      "b2b_tc0_st");
        access(1'b1, 32'h24,   4'b0001, 32'h77,     1, mk_e(32'hDA7A_0024, 0, 4'b0001, 0, 0, 0), "b2b_dm_st");
        @(negedge clk);
        check("b2b_strobe_count", 64'(n_strobe - base_strobe), 64'd2);
`ifdef BRIDGE_PERF_EN
        check("b2b_perf_stall", 64'(perf_stall_cnt), 64'd1);
        check("b2b_perf_err", 64'(perf_err_cnt), 64'd0);
`endif
        @(posedge clk); #1;

        // Illegal timer store through the scoreboard: error, no strobe.
        base_strobe = n_strobe;
        access(1'b1, 32'h7F10, 4'b0001, 32'h9, 1, mk_e(32'h0, 1, 4'h0, 0, 0, 0), "tc1_bad_st");
        @(negedge clk);
        check("tc1_bad_no_strobe", 64'(n_strobe - base_strobe), 64'd0);
`ifdef BRIDGE_PERF_EN
        check("perf_err_one", 64'(perf_err_cnt), 64'd1);
`endif
        @(posedge clk); #1;

        // Reset while an INT store waits: the store never writes.
        base_strobe = n_strobe;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h7F20; cpu_byteen = 4'hF; cpu_wdata = 32'h3;
        @(negedge clk);
        check("int_wait_stall", 64'(obs), 64'(mk(0, 1, 0, 32'h0, 4'h0, 0, 0, 0)));
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("reset_in_wait", 64'(obs), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check("after_reset", 64'(obs), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        check("int_never_written", 64'(n_strobe - base_strobe), 64'd0);

        // Flush in the 2nd cycle of a TC1 store (dut3: TC_WAIT=3).
        sb_en = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h7F14; cpu_byteen = 4'hF; cpu_wdata = 32'h44;
        @(negedge clk);
        check("d3_tc1_stall", 64'(obs3), 64'(mk(0, 1, 0, 32'h0, 4'h0, 0, 0, 0)));
        @(posedge clk); #1;
        cpu_flush = 1'b1;
        @(negedge clk);
        check("d3_flush_cycle", 64'(obs3), 64'd0);
        check("flush_in_ack_cycle", 64'(obs), 64'd0);
        @(posedge clk); #1;
        cpu_flush = 1'b0; cpu_req = 1'b0;
        sticky = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sticky = sticky | d3_tc1_we | tc1_we;
            @(posedge clk); #1;
        end
        check("tc1_never_written", {63'b0, sticky}, 64'd0);

        // dut3 must be idle again: a DM load completes immediately.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_byteen = 4'hF;
        @(negedge clk);
        check("d3_idle_after_flush", 64'(obs3), 64'(mk(1, 0, 0, 32'hDA7A_0040, 4'h0, 0, 0, 0)));
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;

        // dut3 TC0 load: 1 + TC_WAIT = 4 cycles.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h7F08; cpu_byteen = 4'hF;
        lat = 0;
        sticky = 1'b0;
        while (!sticky && lat < 20) begin
            @(negedge clk);
            lat++;
            if (d3_cpu_ack) begin
                sticky = 1'b1;
                check("d3_tc0_rdata", 64'(d3_cpu_rdata), 64'h1234);
            end
            @(posedge clk); #1;
        end
        check("d3_tc0_latency", 64'(lat), 64'd4);
        cpu_req = 1'b0;
        @(posedge clk); #1;

        check("sb_queue_empty", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
